// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding of the
// control FSM and the default iteration count (multiplier width).
// Ports: none (package).
package mult_pkg;

  localparam int ITER_DEFAULT = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ITER  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/multiply_control.sv
// Control FSM for a sequential shift-add multiplier. It sequences the
// Product register: one load cycle, then ITER iterations where each
// iteration is either a single shift cycle (multiplier bit 0) or an add
// cycle followed by a shift cycle (multiplier bit 1), then a one-cycle
// done pulse.
// Ports:
//   clk         - clock, all state changes on rising edge
//   reset       - synchronous active-high reset
//   run         - start request, only honoured in IDLE
//   product_lsb - bit 0 of the Product register (current multiplier bit)
//   wrctrl      - Product register loads the multiplier
//   strctrl     - Product register stores adder result into upper half
//   ready       - Product register holds its value
//   busy        - operation in progress (LOAD, ITER, SHIFT)
//   done        - one-cycle pulse, product complete
module multiply_control
  import mult_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic product_lsb,
  output logic wrctrl,
  output logic strctrl,
  output logic ready,
  output logic busy,
  output logic done
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrctrl  = 1'b0;
    strctrl = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (run) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        wrctrl  = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        busy    = 1'b1;
        // Mealy: an add is needed exactly when the current multiplier bit is 1.
        strctrl = product_lsb;
        if (product_lsb) begin
          state_d = ST_SHIFT;
        end else if (cnt_q == LAST) begin
          // Terminal compare on the pre-increment value; counter is left
          // untouched so it never wraps.
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_ITER;
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_multiply_control.sv
// Scoreboard bench for multiply_control. A small Product-register model
// feeds product_lsb back from the control outputs. Stimulus pushes the
// expected (latency, add-count) for each started operation; a monitor
// measures every operation from its load cycle to its done pulse and
// compares, while also checking per-cycle protocol rules.
module tb_multiply_control;

  typedef struct {
    logic [31:0] mult;
    int          lat;   // done cycle minus load cycle = 1 + 32 + popcount
    int          adds;  // number of strctrl cycles = popcount
  } exp_t;

  logic clk = 1'b0;
  logic reset, run, product_lsb;
  logic wrctrl, strctrl, ready, busy, done;

  logic [31:0] mult_in;
  logic [31:0] mreg;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  multiply_control #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .run(run), .product_lsb(product_lsb),
    .wrctrl(wrctrl), .strctrl(strctrl), .ready(ready), .busy(busy), .done(done)
  );

  // Product register lower half: load, hold, or shift right.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) mreg <= '0;
    else if (wrctrl) mreg <= mult_in;
    else if (!ready && !strctrl) mreg <= mreg >> 1;
  end
  assign product_lsb = mreg[0];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor
  logic in_op = 1'b0;
  logic prev_done = 1'b0;
  int   load_cyc = 0;
  int   adds = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_op     = 1'b0;
      prev_done = 1'b0;
    end else begin
      check("wr_and_str", int'(wrctrl & strctrl), 0);
      check("ctrl_while_ready", int'((wrctrl | strctrl) & ready), 0);
      check("done_width", int'(done & prev_done), 0);
      if (strctrl) check("str_needs_lsb", int'(product_lsb), 1);
      prev_done = done;
      if (wrctrl) begin
        check("load_while_busy", int'(in_op), 0);
        check("load_busy", int'(busy), 1);
        in_op    = 1'b1;
        load_cyc = cyc;
        adds     = 0;
      end else if (in_op) begin
        if (strctrl) adds++;
        if (done) begin
          in_op = 1'b0;
          check("done_ready_busy", int'({ready, busy}), 2);
          if (exp_q.size() == 0) begin
            check("done_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            $display("op mult=%08h latency=%0d adds=%0d (expected %0d/%0d)",
                     e.mult, cyc - load_cyc, adds, e.lat, e.adds);
            check("latency", cyc - load_cyc, e.lat);
            check("add_count", adds, e.adds);
          end
        end else begin
          check("op_ready_busy", int'({ready, busy}), 1);
        end
      end else begin
        check("done_no_op", int'(done), 0);
        check("idle_outputs", int'({wrctrl, strctrl, ready, busy}), 4'b0010);
      end
    end
  end

  task automatic wait_done(input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max_cyc);
    check("done_timeout", int'(done), 1);
  endtask

  task automatic run_op(input logic [31:0] m, input int lat, input int nadd);
    exp_t e;
    @(posedge clk);
    #1;
    mult_in = m;
    run     = 1'b1;
    e.mult = m; e.lat = lat; e.adds = nadd;
    exp_q.push_back(e);
    @(posedge clk);  // edge 0 samples run
    #1;
    run = 1'b0;
    @(negedge clk);  // cycle 1: LOAD
    check("load_cycle1", int'(wrctrl), 1);
    wait_done(200);
  endtask

  initial begin
    exp_t e;
    int gap;
    reset = 1'b1; run = 1'b0; mult_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state", int'({wrctrl, strctrl, ready, busy, done}), 5'b00100);

    // Directed vectors: latency = 1 + 32 + popcount, adds = popcount.
    run_op(32'h0000_0003, 35, 2);
    run_op(32'h0000_0000, 33, 0);
    run_op(32'hFFFF_FFFF, 65, 32);
    run_op(32'h8000_0001, 35, 2);
    run_op(32'h0000_00A5, 37, 4);

    // run held high: second LOAD two cycles after DONE.
    @(posedge clk);
    #1;
    mult_in = 32'h0000_0006;
    run = 1'b1;
    e.mult = 32'h0000_0006; e.lat = 35; e.adds = 2;
    exp_q.push_back(e);
    exp_q.push_back(e);
    wait_done(200);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!wrctrl && gap < 6);
    check("rerun_gap", gap, 2);
    run = 1'b0;
    wait_done(200);

    // Reset in cycle 10 of an operation aborts it without a done pulse.
    @(posedge clk);
    #1;
    mult_in = 32'h0000_00FF;
    run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_outputs", int'({wrctrl, strctrl, ready, busy, done}), 5'b00100);
    repeat (50) @(negedge clk);

    // Full operation after abort.
    run_op(32'h0000_0003, 35, 2);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
